// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, minimum divisor and default sizes.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int UART_MIN_BAUD_DIV = 4;
  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_FIFO_DEPTH   = 16;

  // Clamp the divisor so the mid-bit arithmetic never degenerates.
  function automatic logic [15:0] eff_baud_div(input logic [15:0] div);
    return (div < 16'(UART_MIN_BAUD_DIV)) ? 16'(UART_MIN_BAUD_DIV) : div;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO. A push into a full FIFO is dropped
// (drop_o pulses) unless a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointer and occupancy; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since empty_o masks the head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, stop-bit check,
// sticky framing/overrun flags and an RX FIFO.
// Optional build macro UART_RX_MAJORITY_VOTE_EN: each bit decision becomes a
// 2-of-3 vote over three consecutive samples around the bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  input  logic                  err_clr_i
);

  localparam int BW = $clog2(DATA_WIDTH + 1);

  logic                  sync1_q, rxs_q, prev_q;
  rx_state_e             state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [15:0]           bd_q, bd_d;
  logic [BW-1:0]         bitidx_q, bitidx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  push, frame_set, fifo_drop;
  logic                  start_tick, bit_tick, start_val, bit_val;
  logic [15:0]           half;

  assign half     = bd_q >> 1;
  assign bit_tick = (cnt_q == bd_q - 16'd1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;
  logic       vote;

  // Two-deep history of the synced line; with the current sample this gives three votes.
  always_ff @(posedge clk_i) begin
    if (rst_i) hist_q <= 2'b11;
    else       hist_q <= {hist_q[0], rxs_q};
  end

  assign vote       = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
  assign start_tick = (cnt_q == half + 16'd1);
  assign start_val  = vote;
  assign bit_val    = vote;
`else
  assign start_tick = (cnt_q == half - 16'd1);
  assign start_val  = rxs_q;
  assign bit_val    = rxs_q;
`endif

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_bit_i;
      rxs_q   <= sync1_q;
      prev_q  <= rxs_q;
    end
  end

  // Frame FSM next-state: start validation, data shift-in, stop-bit check.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bd_d      = bd_q;
    bitidx_d  = bitidx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (state_q != IDLE && !rx_en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_en_i && prev_q && !rxs_q) begin
            state_d = START;
            cnt_d   = '0;
            bd_d    = eff_baud_div(baud_div_i);
          end
        end
        START: begin
          if (start_tick) begin
            cnt_d    = '0;
            bitidx_d = '0;
            state_d  = start_val ? IDLE : DATA;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_d  = DATA_WIDTH'({bit_val, shift_q} >> 1);
            cnt_d    = '0;
            bitidx_d = bitidx_q + BW'(1);
            if (bitidx_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            push      = bit_val;
            frame_set = !bit_val;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sticky error flags: a set event wins over a same-cycle clear.
  always_comb begin
    frame_err_d = frame_set | (frame_err_q & ~err_clr_i);
    overrun_d   = fifo_drop | (overrun_q & ~err_clr_i);
  end

  // FSM, counters and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bd_q        <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bd_q        <= bd_d;
      bitidx_q    <= bitidx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  uart_rx_fifo #(
    .WIDTH(DATA_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push),
    .data_i (shift_q),
    .pop_i  (rx_re_i),
    .dout_o (dout_o),
    .empty_o(empty_o),
    .full_o (full_o),
    .drop_o (fifo_drop)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven from a bit-level
// description and results are compared with a queue-based receive model.
`timescale 1ns/1ps
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] baud_div_i = 16'd104;
  logic        rx_en_i = 1'b1;
  logic        rx_bit_i = 1'b1;
  logic        rx_re_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [7:0]  dout_o;
  logic        empty_o, full_o, frame_err_o, overrun_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what a host should see, from frame-level rules only.
  logic [7:0] model_q[$];
  bit         model_ovr = 1'b0;
  bit         model_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .baud_div_i (baud_div_i),
    .rx_en_i    (rx_en_i),
    .rx_bit_i   (rx_bit_i),
    .rx_re_i    (rx_re_i),
    .dout_o     (dout_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .err_clr_i  (err_clr_i)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one 8N1 frame; optional 3-clock low spike inside data bit spike_bit.
  task automatic send_frame(input logic [7:0] b, input int div, input bit stop_ok,
                            input int spike_bit = -1, input int spike_off = 0);
    int bd;
    logic [9:0] bits;
    bd = (div < 4) ? 4 : div;
    bits = {stop_ok, b, 1'b0};
    baud_div_i = div[15:0];
    $display("frame data=%h div=%0d stop=%0d", b, div, stop_ok);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bd; c++) begin
        rx_bit_i = bits[i];
        if (i == spike_bit + 1 && c >= spike_off && c < spike_off + 3) rx_bit_i = 1'b0;
        tick();
      end
    end
    rx_bit_i = 1'b1;
    tick(2 * bd);
  endtask

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) model_ferr = 1'b1;
    else if (model_q.size() < 16) model_q.push_back(b);
    else model_ovr = 1'b1;
  endfunction

  task automatic pop();
    rx_re_i = 1'b1;
    tick();
    rx_re_i = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    tick();
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", empty_o); end
    vectors++; if (full_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full_o); end
    vectors++; if (dout_o !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", dout_o); end
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", frame_err_o); end
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovr got %b want 0", overrun_o); end
  endtask

  task automatic test_basic(input int div, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d, input int n);
    logic [7:0] exp [4];
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    for (int i = 0; i < n; i++) send_frame(exp[i], div, 1'b1);
    for (int i = 0; i < n; i++) begin
      vectors++; if (dout_o !== exp[i]) begin miscompares++; $display("FAIL basic_dout[%0d] got %h want %h", i, dout_o, exp[i]); end
      pop();
    end
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL basic_ferr got %b want 0", frame_err_o); end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL basic_empty got %b want 1", empty_o); end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 16, 1'b0);
    vectors++; if (frame_err_o !== 1'b1) begin miscompares++; $display("FAIL ferr_set got %b want 1", frame_err_o); end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL ferr_empty got %b want 1", empty_o); end
    clear_errs();
    vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL ferr_clr got %b want 0", frame_err_o); end
    send_frame(8'h3C, 16, 1'b1);
    vectors++; if (dout_o !== 8'h3C || empty_o !== 1'b0) begin miscompares++; $display("FAIL ferr_good got %h/%b want 3c/0", dout_o, empty_o); end
    pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 16, 1'b1);
      if (i == 15) begin
        vectors++; if (full_o !== 1'b1 || overrun_o !== 1'b0) begin miscompares++; $display("FAIL ovr_full got full=%b ovr=%b want 1/0", full_o, overrun_o); end
      end
    end
    vectors++; if (overrun_o !== 1'b1) begin miscompares++; $display("FAIL ovr_set got %b want 1", overrun_o); end
    for (int i = 0; i < 16; i++) begin
      vectors++; if (dout_o !== 8'(i)) begin miscompares++; $display("FAIL ovr_dout[%0d] got %h want %h", i, dout_o, 8'(i)); end
      pop();
    end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL ovr_empty got %b want 1", empty_o); end
    clear_errs();
    vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL ovr_clr got %b want 0", overrun_o); end
  endtask

  task automatic test_glitch();
    int off;
    baud_div_i = 16'd104;
    rx_bit_i = 1'b0;
    tick(20);
    rx_bit_i = 1'b1;
    tick(400);
    vectors++; if (empty_o !== 1'b1 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL glitch got empty=%b ferr=%b ovr=%b want 1/0/0", empty_o, frame_err_o, overrun_o);
    end
`ifdef UART_RX_MAJORITY_VOTE_EN
    off = 50;
`else
    off = 10;
`endif
    send_frame(8'hF0, 104, 1'b1, 5, off);
    vectors++; if (dout_o !== 8'hF0 || empty_o !== 1'b0) begin miscompares++; $display("FAIL spike got %h/%b want f0/0", dout_o, empty_o); end
    pop();
  endtask

  task automatic test_disable();
    baud_div_i = 16'd16;
    rx_bit_i = 1'b0;
    tick(16 * 3);
    rx_en_i = 1'b0;
    tick(16 * 5);
    rx_bit_i = 1'b1;
    tick(16 * 3);
    rx_en_i = 1'b1;
    tick(32);
    vectors++; if (empty_o !== 1'b1 || frame_err_o !== 1'b0) begin miscompares++; $display("FAIL disable got empty=%b ferr=%b want 1/0", empty_o, frame_err_o); end
    send_frame(8'h99, 16, 1'b1);
    vectors++; if (dout_o !== 8'h99) begin miscompares++; $display("FAIL disable_after got %h want 99", dout_o); end
    pop();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a5;
    a5 = 8'hA5;
    send_frame(8'h11, 16, 1'b1);
    send_frame(8'h22, 16, 1'b0);
    vectors++; if (frame_err_o !== 1'b1 || empty_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre got ferr=%b empty=%b want 1/0", frame_err_o, empty_o); end
    baud_div_i = 16'd16;
    rx_bit_i = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      rx_bit_i = a5[i];
      tick(16);
    end
    rst_i = 1'b1;
    tick();
    vectors++; if (empty_o !== 1'b1 || frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin
      miscompares++; $display("FAIL rstmid got empty=%b ferr=%b ovr=%b want 1/0/0", empty_o, frame_err_o, overrun_o);
    end
    rst_i = 1'b0;
    rx_bit_i = 1'b1;
    tick(32);
    send_frame(8'h5A, 16, 1'b1);
    vectors++; if (dout_o !== 8'h5A) begin miscompares++; $display("FAIL rstmid_next got %h want 5a", dout_o); end
    pop();
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_empty got %b want 1", empty_o); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit ok;
    int div;
    model_q.delete();
    model_ovr = 1'b0;
    model_ferr = 1'b0;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      div = int'($urandom_range(2, 24));
      ok = ($urandom_range(0, 9) != 0);
      send_frame(b, div, ok);
      model_frame(b, ok);
      if ($urandom_range(0, 9) < 3 && model_q.size() > 0) begin
        vectors++; if (dout_o !== model_q[0]) begin miscompares++; $display("FAIL rand_dout[%0d] got %h want %h", n, dout_o, model_q[0]); end
        void'(model_q.pop_front());
        pop();
      end
    end
    vectors++; if (frame_err_o !== model_ferr) begin miscompares++; $display("FAIL rand_ferr got %b want %b", frame_err_o, model_ferr); end
    vectors++; if (overrun_o !== model_ovr) begin miscompares++; $display("FAIL rand_ovr got %b want %b", overrun_o, model_ovr); end
    while (model_q.size() > 0) begin
      vectors++; if (dout_o !== model_q[0]) begin miscompares++; $display("FAIL rand_drain got %h want %h", dout_o, model_q[0]); end
      void'(model_q.pop_front());
      pop();
    end
    vectors++; if (empty_o !== 1'b1) begin miscompares++; $display("FAIL rand_empty got %b want 1", empty_o); end
    clear_errs();
  endtask

  initial begin
    test_reset();
    test_basic(104, 8'h41, 8'h42, 8'h43, 8'h0A, 4);
    test_basic(16, 8'h55, 8'hAA, 8'h00, 8'h00, 2);
    test_frame_err();
    test_overrun();
    test_glitch();
    test_disable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
